// File: rtl/histogram_fwd_param_if.sv
// histogram_fwd_param_if: control handshake plus sample/bin RAM bus of the histogram kernel
//   start/clear_first/num_samples : run request, sampled together
//   busy/valid/sat                : run status
//   arg_0_*                       : sample RAM read port
//   arg_1_*                       : bin RAM read and write ports
//   master = wrapper/RAM side, slave = kernel side
interface histogram_fwd_param_if #(parameter int SAMPLE_W = 8, ADDR_W = 12, COUNT_W = 32);
  logic                start;
  logic                clear_first;
  logic [ADDR_W:0]     num_samples;
  logic                busy;
  logic                valid;
  logic                sat;
  logic [ADDR_W-1:0]   arg_0_raddr_0;
  logic [SAMPLE_W-1:0] arg_0_rdata_0;
  logic [SAMPLE_W-1:0] arg_1_raddr_0;
  logic [COUNT_W-1:0]  arg_1_rdata_0;
  logic [SAMPLE_W-1:0] arg_1_waddr_0;
  logic [COUNT_W-1:0]  arg_1_wdata_0;
  logic                arg_1_wen_0;
  modport master (
    output start, clear_first, num_samples, arg_0_rdata_0, arg_1_rdata_0,
    input  busy, valid, sat, arg_0_raddr_0, arg_1_raddr_0, arg_1_waddr_0, arg_1_wdata_0, arg_1_wen_0
  );
  modport slave (
    input  start, clear_first, num_samples, arg_0_rdata_0, arg_1_rdata_0,
    output busy, valid, sat, arg_0_raddr_0, arg_1_raddr_0, arg_1_waddr_0, arg_1_wdata_0, arg_1_wen_0
  );
endinterface

// File: rtl/histogram_fwd_param.sv
// histogram_fwd_param: II=1 histogram kernel with previous-write forwarding, optional bin clear and saturating counts
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : histogram_fwd_param_if slave (handshake, sample RAM read, bin RAM read/write)
module histogram_fwd_param #(
  parameter int SAMPLE_W = 8,
  parameter int ADDR_W   = 12,
  parameter int COUNT_W  = 32
) (
  input logic clk,
  input logic rst,
  histogram_fwd_param_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
  state_t              state_q;
  logic [ADDR_W:0]     cnt_q, n_q;
  logic [SAMPLE_W-1:0] clr_q, p_q, lw_a_q;
  logic [COUNT_W-1:0]  lw_d_q, base_d, wdata_d;
  logic                v1_q, v2_q, v3_q, drn_q, busy_q, valid_q, sat_q;
  logic                issue_d, clr_d, full_d;
  always_comb begin
    issue_d = state_q == RUN && n_q != '0;
    clr_d   = state_q == CLEAR;
    // v3_q marks a write in the previous cycle; the RAM still returns the pre-write value for it
    base_d  = (v3_q && lw_a_q == p_q) ? lw_d_q : bus.arg_1_rdata_0;
    full_d  = &base_d;
    wdata_d = full_d ? base_d : base_d + COUNT_W'(1);
  end
  assign bus.arg_0_raddr_0 = issue_d ? cnt_q[ADDR_W-1:0] : '0;
  assign bus.arg_1_raddr_0 = v1_q ? bus.arg_0_rdata_0 : '0;
  assign bus.arg_1_waddr_0 = v2_q ? p_q : (clr_d ? clr_q : '0);
  assign bus.arg_1_wdata_0 = v2_q ? wdata_d : '0;
  assign bus.arg_1_wen_0   = v2_q | clr_d;
  assign bus.busy          = busy_q;
  assign bus.valid         = valid_q;
  assign bus.sat           = sat_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      clr_q   <= '0;
      p_q     <= '0;
      lw_a_q  <= '0;
      lw_d_q  <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      drn_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      v1_q   <= issue_d;
      v2_q   <= v1_q;
      v3_q   <= v2_q;
      p_q    <= bus.arg_0_rdata_0;
      lw_a_q <= p_q;
      lw_d_q <= wdata_d;
      if (v2_q && full_d) sat_q <= 1'b1;
      case (state_q)
        IDLE, DONE: if (bus.start) begin
          state_q <= bus.clear_first ? CLEAR : RUN;
          n_q     <= bus.num_samples;
          cnt_q   <= '0;
          clr_q   <= '0;
          sat_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        CLEAR: begin
          clr_q <= clr_q + SAMPLE_W'(1);
          if (&clr_q) state_q <= RUN;
        end
        RUN: if (n_q == '0) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + (ADDR_W+1)'(1);
          if (cnt_q == n_q - (ADDR_W+1)'(1)) begin
            state_q <= DRAIN;
            drn_q   <= 1'b0;
          end
        end
        DRAIN: begin
          drn_q <= 1'b1;
          if (drn_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_histogram_fwd_param.sv
// tb_histogram_fwd_param: directed checks of the histogram kernel against hand-computed bin counts and latencies
module tb_histogram_fwd_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  int wen_cnt = 0;
  logic [7:0]  smem [4096];
  logic [31:0] bm32 [256];
  logic [3:0]  bm4  [256];
  always #5 clk = ~clk;
  histogram_fwd_param_if #(.SAMPLE_W(8), .ADDR_W(12), .COUNT_W(32)) b32();
  histogram_fwd_param_if #(.SAMPLE_W(8), .ADDR_W(12), .COUNT_W(4))  b4();
  histogram_fwd_param #(.SAMPLE_W(8), .ADDR_W(12), .COUNT_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  histogram_fwd_param #(.SAMPLE_W(8), .ADDR_W(12), .COUNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
  always @(posedge clk) begin
    b32.arg_0_rdata_0 <= smem[b32.arg_0_raddr_0];
    b32.arg_1_rdata_0 <= bm32[b32.arg_1_raddr_0];
    if (b32.arg_1_wen_0) bm32[b32.arg_1_waddr_0] <= b32.arg_1_wdata_0;
    b4.arg_0_rdata_0 <= smem[b4.arg_0_raddr_0];
    b4.arg_1_rdata_0 <= bm4[b4.arg_1_raddr_0];
    if (b4.arg_1_wen_0) bm4[b4.arg_1_waddr_0] <= b4.arg_1_wdata_0;
  end
  always @(negedge clk) if (b32.arg_1_wen_0) wen_cnt++;
  task automatic run32(input logic cf, input int n, input int poke, output int cyc);
    @(negedge clk);
    b32.start = 1'b1;
    b32.clear_first = cf;
    b32.num_samples = 13'(n);
    @(posedge clk);
    #1 b32.start = 1'b0;
    cyc = 1;
    while (!b32.valid && cyc < 3000) begin
      b32.start = (cyc == poke);
      if (cyc == poke) begin
        b32.clear_first = 1'b0;
        b32.num_samples = 13'd5;
      end
      @(posedge clk);
      #1 cyc++;
    end
    b32.start = 1'b0;
    if (!b32.valid) cyc = -1;
  endtask
  task automatic test_reset();
    b32.start = 0; b32.clear_first = 0; b32.num_samples = 0;
    b4.start = 0; b4.clear_first = 0; b4.num_samples = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({b32.busy, b32.valid, b32.sat, b32.arg_1_wen_0} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {b32.busy, b32.valid, b32.sat, b32.arg_1_wen_0}); end
    total++; if (b32.arg_0_raddr_0 !== 12'd0) begin bad++; $display("FAIL reset_raddr0 got=%0d want=0", b32.arg_0_raddr_0); end
    total++; if ({b32.arg_1_raddr_0, b32.arg_1_waddr_0, b32.arg_1_wdata_0} !== 48'd0) begin bad++; $display("FAIL reset_bin_bus got=%h want=0", {b32.arg_1_raddr_0, b32.arg_1_waddr_0, b32.arg_1_wdata_0}); end
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_mod7();
    int cyc;
    for (int i = 0; i < 100; i++) smem[i] = 8'(i % 7);
    run32(1'b1, 100, -1, cyc);
    total++; if (cyc !== 359) begin bad++; $display("FAIL mod7_latency got=%0d want=359", cyc); end
    total++; if (b32.sat !== 1'b0) begin bad++; $display("FAIL mod7_sat got=%b want=0", b32.sat); end
    for (int i = 0; i < 256; i++) begin
      total++;
      if (bm32[i] !== (i < 2 ? 32'd15 : i < 7 ? 32'd14 : 32'd0)) begin bad++; $display("FAIL mod7_bin%0d got=%0d want=%0d", i, bm32[i], i < 2 ? 15 : i < 7 ? 14 : 0); end
    end
  endtask
  task automatic test_back_to_back();
    int cyc;
    for (int i = 0; i < 50; i++) smem[i] = 8'h2A;
    run32(1'b1, 50, -1, cyc);
    total++; if (cyc !== 309) begin bad++; $display("FAIL b2b_latency got=%0d want=309", cyc); end
    total++; if (bm32[42] !== 32'd50) begin bad++; $display("FAIL b2b_bin42 got=%0d want=50", bm32[42]); end
    total++; if (bm32[0] !== 32'd0) begin bad++; $display("FAIL b2b_bin0_cleared got=%0d want=0", bm32[0]); end
  endtask
  task automatic test_alternate();
    int cyc;
    for (int i = 0; i < 40; i++) smem[i] = (i % 2 == 0) ? 8'h11 : 8'h22;
    run32(1'b1, 40, -1, cyc);
    total++; if (cyc !== 299) begin bad++; $display("FAIL alt_latency got=%0d want=299", cyc); end
    total++; if (bm32[17] !== 32'd20) begin bad++; $display("FAIL alt_binA got=%0d want=20", bm32[17]); end
    total++; if (bm32[34] !== 32'd20) begin bad++; $display("FAIL alt_binB got=%0d want=20", bm32[34]); end
    total++; if (bm32[42] !== 32'd0) begin bad++; $display("FAIL alt_bin42_cleared got=%0d want=0", bm32[42]); end
    run32(1'b0, 40, -1, cyc);
    total++; if (cyc !== 43) begin bad++; $display("FAIL accum_latency got=%0d want=43", cyc); end
    total++; if (bm32[17] !== 32'd40) begin bad++; $display("FAIL accum_binA got=%0d want=40", bm32[17]); end
    total++; if (bm32[34] !== 32'd40) begin bad++; $display("FAIL accum_binB got=%0d want=40", bm32[34]); end
  endtask
  task automatic test_saturate();
    int cyc;
    for (int i = 0; i < 20; i++) smem[i] = 8'd3;
    @(negedge clk);
    b4.start = 1'b1; b4.clear_first = 1'b1; b4.num_samples = 13'd20;
    @(posedge clk);
    #1 b4.start = 1'b0;
    cyc = 1;
    while (!b4.valid && cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
    end
    total++; if (cyc !== 279) begin bad++; $display("FAIL sat_latency got=%0d want=279", cyc); end
    total++; if (bm4[3] !== 4'd15) begin bad++; $display("FAIL sat_bin3 got=%0d want=15", bm4[3]); end
    total++; if (b4.sat !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", b4.sat); end
    total++; if (bm4[4] !== 4'd0) begin bad++; $display("FAIL sat_bin4 got=%0d want=0", bm4[4]); end
  endtask
  task automatic test_zero_len();
    int cyc;
    wen_cnt = 0;
    run32(1'b0, 0, -1, cyc);
    repeat (3) @(posedge clk);
    #1;
    total++; if (cyc !== 2) begin bad++; $display("FAIL zero_latency got=%0d want=2", cyc); end
    total++; if (wen_cnt !== 0) begin bad++; $display("FAIL zero_wen_pulses got=%0d want=0", wen_cnt); end
    total++; if (bm32[17] !== 32'd40) begin bad++; $display("FAIL zero_bin_untouched got=%0d want=40", bm32[17]); end
  endtask
  task automatic test_reset_mid_run();
    int cyc;
    for (int i = 0; i < 100; i++) smem[i] = 8'(i % 7);
    @(negedge clk);
    b32.start = 1'b1; b32.clear_first = 1'b0; b32.num_samples = 13'd100;
    @(posedge clk);
    #1 b32.start = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    total++; if ({b32.busy, b32.arg_1_wen_0} !== 2'b11) begin bad++; $display("FAIL midrun_active got=%b want=11", {b32.busy, b32.arg_1_wen_0}); end
    #1 rst = 1'b0;
    #1;
    total++; if ({b32.busy, b32.valid, b32.arg_1_wen_0} !== 3'b0) begin bad++; $display("FAIL async_flags got=%b want=000", {b32.busy, b32.valid, b32.arg_1_wen_0}); end
    total++; if ({b32.arg_0_raddr_0, b32.arg_1_raddr_0, b32.arg_1_waddr_0} !== 28'd0) begin bad++; $display("FAIL async_addrs got=%h want=0", {b32.arg_0_raddr_0, b32.arg_1_raddr_0, b32.arg_1_waddr_0}); end
    @(negedge clk);
    rst = 1'b1;
    run32(1'b1, 100, 300, cyc);
    total++; if (cyc !== 359) begin bad++; $display("FAIL rerun_latency got=%0d want=359", cyc); end
    total++; if (bm32[0] !== 32'd15) begin bad++; $display("FAIL rerun_bin0 got=%0d want=15", bm32[0]); end
    total++; if (bm32[6] !== 32'd14) begin bad++; $display("FAIL rerun_bin6 got=%0d want=14", bm32[6]); end
    total++; if (bm32[17] !== 32'd0) begin bad++; $display("FAIL rerun_bin17 got=%0d want=0", bm32[17]); end
  endtask
  initial begin
    test_reset();
    test_mod7();
    test_back_to_back();
    test_alternate();
    test_saturate();
    test_zero_len();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
